dg_sequencer: RTL
=================

Name: dg_sequencer

Overview:
- Run controller for the digital generator datapath (counter → toggle → inv → delay).
- Drives the generator's `ctrl` input with a programmable run/gap duty pattern.
- Counts completed counter loops by watching the generator's `enable` output toggle.
- Stops the generator after a programmed number of loops and reports completion to the higher-level control.

Parameters:
- LOOP_W, 8: width of loop-count configuration and status.
- LEN_W, 8: width of run-length and gap-length configuration and internal phase counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request a sequence; accepted only in IDLE.
- abort  in  1  terminate the current sequence immediately, without `done`.
- cfg_loops  in  LOOP_W  number of generator loops to run; 0 = finish immediately.
- cfg_run_len  in  LEN_W  cycles of `dg_ctrl`=1 per run phase; 0 = continuous, no gaps.
- cfg_gap_len  in  LEN_W  cycles of `dg_ctrl`=0 between run phases; 0 = no gaps.
- dg_enable  in  1  generator `enable` output; each transition = one completed loop.
- dg_ctrl  out  1  drives generator `ctrl`.
- busy  out  1  high while a sequence is active.
- done  out  1  one-cycle pulse on normal completion.
- loops_done  out  LOOP_W  loops completed in current/last sequence.

Behaviour:
- Reset (rst_n=0 at a clock edge): state IDLE; `dg_ctrl`=0, `busy`=0, `done`=0, `loops_done`=0; edge register = 0; phase counter = 0. Reset overrides all inputs and aborts any sequence.
- All outputs are registered.
- States:
  - IDLE: `dg_ctrl`=0.
  - RUN: `dg_ctrl`=1.
  - GAP: `dg_ctrl`=0.
  - `busy` = (state != IDLE).
- Config capture: `cfg_*` are latched on start acceptance and ignored afterwards.
- Start: `start`=1 in IDLE with `abort`=0 at cycle t:
  - `loops_done` cleared at t+1.
  - If `cfg_loops`!=0: state RUN, `dg_ctrl`=1, `busy`=1 at t+1.
  - If `cfg_loops`==0: stay IDLE, `done`=1 at t+1, `dg_ctrl` never asserted.
- Start while busy is ignored.
- Phase timing:
  - Phase counter clears on every state entry.
  - RUN lasts exactly `cfg_run_len` cycles, then GAP if `cfg_gap_len`!=0, else RUN restarts (`dg_ctrl` stays 1).
  - GAP lasts exactly `cfg_gap_len` cycles, then RUN.
  - `cfg_run_len`=0: remain in RUN until loops complete.
- Loop detection:
  - `dg_enable` is registered every cycle, including IDLE.
  - edge = `dg_enable` XOR registered value.
  - Edges count only in RUN or GAP; edges in IDLE are ignored. A late edge arriving in the first GAP cycle still counts.
  - Each counted edge increments `loops_done` by 1 (no wrap; sequence ends at `cfg_loops`).
- Completion: edge at cycle e making `loops_done`==`cfg_loops`:
  - at e+1: state IDLE, `dg_ctrl`=0, `busy`=0, `done`=1, `loops_done`=`cfg_loops`.
  - `done` deasserts at e+2.
- Abort:
  - `abort`=1 in RUN/GAP at cycle a: IDLE at a+1, `dg_ctrl`=0, `busy`=0, no `done`; `loops_done` holds its value.
  - Abort beats a simultaneous final edge: no `done`, and that edge is not counted.
  - `start` and `abort` together in IDLE: abort wins, nothing starts.
- Phase boundary plus final edge in the same cycle: completion wins; go to IDLE, not GAP.

Test Plan:
1. Reset mid-RUN (rst_n=0 one cycle while `dg_ctrl`=1) → next cycle `dg_ctrl`=0, `busy`=0, `loops_done`=0, no `done`.
2. `cfg_loops`=3, `cfg_run_len`=0, bench toggles `dg_enable` every 4 `dg_ctrl`-high cycles; start at t → `dg_ctrl`=1 from t+1; `loops_done` steps 1,2,3; `done` pulses once one cycle after the 3rd toggle, same cycle `dg_ctrl`=0.
3. `cfg_loops`=2, `cfg_run_len`=3, `cfg_gap_len`=2 → `dg_ctrl` pattern 1,1,1,0,0,1,1,1,0,0… until 2nd toggle; each GAP exactly 2 cycles.
4. `cfg_loops`=0, start → `done`=1 next cycle, `busy` never 1, `dg_ctrl` never 1.
5. `cfg_loops`=5, abort asserted in the cycle of the 2nd toggle → IDLE next cycle, `loops_done`=1, no `done`; start during the active sequence had no effect.
6. `dg_enable` toggles while IDLE, then start with `cfg_loops`=1 → `loops_done`=0 until first toggle after start; single toggle → `done`.

Source files
------------

// File: rtl/dg_sequencer_if.sv
// Signal bundle between the higher-level control / generator and dg_sequencer.
// Both the control side and the generator feedback are grouped here.
interface dg_sequencer_if #(
    parameter int LOOP_W = 8,
    parameter int LEN_W  = 8
);
    logic              start;
    logic              abort;
    logic [LOOP_W-1:0] cfg_loops;
    logic [LEN_W-1:0]  cfg_run_len;
    logic [LEN_W-1:0]  cfg_gap_len;
    logic              dg_enable;
    logic              dg_ctrl;
    logic              busy;
    logic              done;
    logic [LOOP_W-1:0] loops_done;

    modport master (
        output start, abort, cfg_loops, cfg_run_len, cfg_gap_len, dg_enable,
        input  dg_ctrl, busy, done, loops_done
    );

    modport slave (
        input  start, abort, cfg_loops, cfg_run_len, cfg_gap_len, dg_enable,
        output dg_ctrl, busy, done, loops_done
    );
endinterface

// File: rtl/dg_sequencer.sv
// Run controller for the digital generator: produces the run/gap ctrl pattern,
// counts generator loops from enable toggles and stops after cfg_loops loops.
module dg_sequencer #(
    parameter int LOOP_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    dg_sequencer_if.slave     bus,
    output logic [1:0]        dbg_state_o
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  phase_q, phase_d;
    logic [LOOP_W-1:0] loops_q, loops_d;
    logic [LOOP_W-1:0] cfg_loops_q, cfg_loops_d;
    logic [LEN_W-1:0]  run_len_q, run_len_d;
    logic [LEN_W-1:0]  gap_len_q, gap_len_d;
    logic              en_q;
    logic              done_q, done_d;
    logic              ctrl_q, busy_q;

    logic              edge_w;
    logic [LOOP_W-1:0] loops_inc;
    logic [LEN_W-1:0]  phase_inc;

    assign edge_w    = bus.dg_enable ^ en_q;
    assign loops_inc = loops_q + 1'b1;
    assign phase_inc = phase_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        loops_d     = loops_q;
        cfg_loops_d = cfg_loops_q;
        run_len_d   = run_len_q;
        gap_len_d   = gap_len_q;
        done_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    loops_d     = '0;
                    cfg_loops_d = bus.cfg_loops;
                    run_len_d   = bus.cfg_run_len;
                    gap_len_d   = bus.cfg_gap_len;
                    phase_d     = '0;
                    if (bus.cfg_loops == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN, GAP: begin
                // Priority: abort, then completion, then ordinary phase stepping.
                if (bus.abort) begin
                    state_d = IDLE;
                    phase_d = '0;
                end else if (edge_w && (loops_inc == cfg_loops_q)) begin
                    state_d = IDLE;
                    phase_d = '0;
                    done_d  = 1'b1;
                    loops_d = cfg_loops_q;
                end else begin
                    if (edge_w) begin
                        loops_d = loops_inc;
                    end
                    if (state_q == RUN) begin
                        if (run_len_q == '0) begin
                            phase_d = '0;
                        end else if (phase_inc == run_len_q) begin
                            state_d = (gap_len_q != '0) ? GAP : RUN;
                            phase_d = '0;
                        end else begin
                            phase_d = phase_inc;
                        end
                    end else begin
                        if (phase_inc == gap_len_q) begin
                            state_d = RUN;
                            phase_d = '0;
                        end else begin
                            phase_d = phase_inc;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            loops_q     <= '0;
            cfg_loops_q <= '0;
            run_len_q   <= '0;
            gap_len_q   <= '0;
            en_q        <= 1'b0;
            done_q      <= 1'b0;
            ctrl_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            loops_q     <= loops_d;
            cfg_loops_q <= cfg_loops_d;
            run_len_q   <= run_len_d;
            gap_len_q   <= gap_len_d;
            en_q        <= bus.dg_enable;
            done_q      <= done_d;
            ctrl_q      <= (state_d == RUN);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign bus.dg_ctrl    = ctrl_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.loops_done = loops_q;
    assign dbg_state_o    = state_q;
endmodule
